verifuck_stdin_rx: RTL

UART receive front-end that feeds the verifuck CPU's stdin (the `,` instruction). It deserialises 8N1 frames from `uart_rx_pin` and buffers the bytes in a small FIFO. The CPU consumes them through a valid/read handshake. It is the input-side counterpart of the stdout/UART TX path and runs on the same clock as the CPU.

---
 rtl/verifuck_stdin_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/verifuck_stdin_rx.sv
// verifuck_stdin_rx: 8N1 UART receiver feeding a small stdin FIFO.
// The CPU pops bytes through a valid/read handshake. Overrun and framing
// errors are sticky until reset.
module verifuck_stdin_rx #(
    parameter int UART_RX_BAUD = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_pin,
    output logic [7:0] stdin,
    output logic       stdin_valid,
    input  logic       stdin_rd,
    output logic       rx_busy,
    output logic       overrun_err,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(UART_RX_BAUD);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'((UART_RX_BAUD >> 1) - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(UART_RX_BAUD - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic             rx_meta_q, rx_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req, ferr_set;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wptr_q, rptr_q;
    logic [7:0]       stdin_q;
    logic             valid_q, ovr_q, ferr_q;
    logic             empty, full, pop, push;

    // Two-flop synchroniser on the asynchronous serial line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_pin;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: each state counts down to zero, then samples rx_s.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s_q) begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = FULL_M1;
                end else begin
                    state_d = IDLE;  // start bit did not hold: glitch
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s_q) begin
                    push_req = 1'b1;
                    state_d  = IDLE;  // back at mid-stop-bit, ready for next start
                end else begin
                    ferr_set = 1'b1;
                    state_d  = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not look like a string of start bits.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) && (wptr_q[PTR_W] != rptr_q[PTR_W]);
    // stdin_valid lags the pointers by a cycle; the empty guard keeps a
    // held stdin_rd from popping past the last entry during that cycle.
    assign pop   = stdin_rd && valid_q && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = push_req && (!full || pop);

    // FIFO storage, pointers, registered head/valid and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            stdin_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q[PTR_W-1:0]] <= shift_q;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            stdin_q <= mem_q[rptr_q[PTR_W-1:0]];
            valid_q <= !empty;
            if (push_req && !push) ovr_q  <= 1'b1;
            if (ferr_set)          ferr_q <= 1'b1;
        end
    end

    assign stdin       = stdin_q;
    assign stdin_valid = valid_q;
    assign rx_busy     = (state_q != IDLE);
    assign overrun_err = ovr_q;
    assign frame_err   = ferr_q;

endmodule
